// File: rtl/bydin_rs_arb.sv
// Round-robin owner of the shared RS(240,K) decoder for the two bydin
// timeslot deinterleaver channels: grant, stream one row, collect status.
module bydin_rs_arb #(
    parameter int unsigned ROW_LEN = 240,
    parameter int unsigned TO_CYC  = 2047
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ts0_row_req,
    input  logic [1:0] ts0_rs_mode,
    output logic       ts0_byte_rd,
    input  logic [7:0] ts0_byte,
    output logic       ts0_row_done,
    output logic       ts0_row_fail,
    input  logic       ts1_row_req,
    input  logic [1:0] ts1_rs_mode,
    output logic       ts1_byte_rd,
    input  logic [7:0] ts1_byte,
    output logic       ts1_row_done,
    output logic       ts1_row_fail,
    output logic       rs_en_in,
    output logic [7:0] rs_din,
    output logic [1:0] rs_mode,
    input  logic       rs_row_finish,
    input  logic       rs_cor_fail,
    output logic       rs_busy,
    output logic       rs_timeout
);

    localparam int unsigned CNT_W = $clog2(ROW_LEN);
    localparam int unsigned TO_W  = 11;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(ROW_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        WAIT
    } state_e;

    state_e           state_q;
    logic             owner_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             drain_q;
    logic [1:0]       mode_q;
    logic             rd0_q;
    logic             rd1_q;
    logic             rd_dly_q;
    logic             en_q;
    logic [7:0]       din_q;
    logic             done0_q;
    logic             done1_q;
    logic             fail0_q;
    logic             fail1_q;
    logic             to_q;

    logic             grant_vld_d;
    logic             grant_ch_d;
    logic [7:0]       owner_byte;
    logic             done_any;

    // Owner of a tie is the channel that did not win last time.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_ch_d  = 1'b0;
        unique case (1'b1)
            (ts0_row_req && ts1_row_req): begin
                grant_vld_d = 1'b1;
                grant_ch_d  = ~last_grant_q;
            end
            (ts0_row_req && !ts1_row_req): begin
                grant_vld_d = 1'b1;
                grant_ch_d  = 1'b0;
            end
            (ts1_row_req && !ts0_row_req): begin
                grant_vld_d = 1'b1;
                grant_ch_d  = 1'b1;
            end
            default: begin
                grant_vld_d = 1'b0;
                grant_ch_d  = 1'b0;
            end
        endcase
    end

    assign owner_byte = owner_q ? ts1_byte : ts0_byte;
    assign done_any   = done0_q | done1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            byte_cnt_q   <= '0;
            to_cnt_q     <= '0;
            drain_q      <= 1'b0;
            mode_q       <= 2'b00;
            rd0_q        <= 1'b0;
            rd1_q        <= 1'b0;
            rd_dly_q     <= 1'b0;
            en_q         <= 1'b0;
            din_q        <= 8'h00;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            fail0_q      <= 1'b0;
            fail1_q      <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            // Read strobe -> buffer data -> decoder byte, two stages.
            rd_dly_q <= rd0_q | rd1_q;
            en_q     <= rd_dly_q;
            din_q    <= rd_dly_q ? owner_byte : 8'h00;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            fail0_q  <= 1'b0;
            fail1_q  <= 1'b0;
            to_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Hold off while row_done is out so the owner can drop req.
                    if (grant_vld_d && !done_any) begin
                        owner_q      <= grant_ch_d;
                        last_grant_q <= grant_ch_d;
                        mode_q       <= grant_ch_d ? ts1_rs_mode : ts0_rs_mode;
                        rd0_q        <= ~grant_ch_d;
                        rd1_q        <= grant_ch_d;
                        byte_cnt_q   <= '0;
                        state_q      <= FEED;
                    end
                end
                FEED: begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        rd0_q   <= 1'b0;
                        rd1_q   <= 1'b0;
                        drain_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        to_cnt_q <= '0;
                        state_q  <= WAIT;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                WAIT: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (rs_row_finish) begin
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        fail0_q <= ~owner_q & rs_cor_fail;
                        fail1_q <= owner_q & rs_cor_fail;
                        state_q <= IDLE;
                    end else if (to_cnt_q == TO_LAST) begin
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        fail0_q <= ~owner_q;
                        fail1_q <= owner_q;
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ts0_byte_rd  = rd0_q;
    assign ts1_byte_rd  = rd1_q;
    assign ts0_row_done = done0_q;
    assign ts1_row_done = done1_q;
    assign ts0_row_fail = fail0_q;
    assign ts1_row_fail = fail1_q;
    assign rs_en_in     = en_q;
    assign rs_din       = din_q;
    assign rs_mode      = mode_q;
    assign rs_busy      = (state_q != IDLE);
    assign rs_timeout   = to_q;

endmodule

// File: tb/tb_bydin_rs_arb.sv
// Directed bench for bydin_rs_arb: channel buffers feed a byte
// scoreboard, grants and row status are checked against queued expectations.
module tb_bydin_rs_arb;

    logic       clk;
    logic       reset_n;
    logic       ts0_row_req;
    logic [1:0] ts0_rs_mode;
    logic       ts0_byte_rd;
    logic [7:0] ts0_byte;
    logic       ts0_row_done;
    logic       ts0_row_fail;
    logic       ts1_row_req;
    logic [1:0] ts1_rs_mode;
    logic       ts1_byte_rd;
    logic [7:0] ts1_byte;
    logic       ts1_row_done;
    logic       ts1_row_fail;
    logic       rs_en_in;
    logic [7:0] rs_din;
    logic [1:0] rs_mode;
    logic       rs_row_finish;
    logic       rs_cor_fail;
    logic       rs_busy;
    logic       rs_timeout;

    bydin_rs_arb dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ts0_row_req  (ts0_row_req),
        .ts0_rs_mode  (ts0_rs_mode),
        .ts0_byte_rd  (ts0_byte_rd),
        .ts0_byte     (ts0_byte),
        .ts0_row_done (ts0_row_done),
        .ts0_row_fail (ts0_row_fail),
        .ts1_row_req  (ts1_row_req),
        .ts1_rs_mode  (ts1_rs_mode),
        .ts1_byte_rd  (ts1_byte_rd),
        .ts1_byte     (ts1_byte),
        .ts1_row_done (ts1_row_done),
        .ts1_row_fail (ts1_row_fail),
        .rs_en_in     (rs_en_in),
        .rs_din       (rs_din),
        .rs_mode      (rs_mode),
        .rs_row_finish(rs_row_finish),
        .rs_cor_fail  (rs_cor_fail),
        .rs_busy      (rs_busy),
        .rs_timeout   (rs_timeout)
    );

    localparam int ROW = 240;
    localparam int TOC = 2047;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] sb[$];
    logic [2:0] exp_grant[$];
    logic [2:0] exp_done[$];

    int rd0_run = 0;
    int rd1_run = 0;
    int en_run = 0;
    int rd0_tot = 0;
    int rd1_tot = 0;
    int en_tot = 0;
    int done_tot = 0;
    int rows_streamed = 0;
    int last_en_cyc = 0;
    int done_cyc = 0;
    logic [1:0] cur_mode = 2'b00;
    logic prev_rd = 1'b0;

    logic [18:0] outs;
    assign outs = {ts0_byte_rd, ts0_row_done, ts0_row_fail,
                   ts1_byte_rd, ts1_row_done, ts1_row_fail,
                   rs_en_in, rs_din, rs_mode, rs_busy, rs_timeout};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int ch, input int row, input int idx);
        return 8'(idx * 13 + row * 37 + ch * 101 + 5);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Channel row buffers: data valid the cycle after a read strobe.
    initial begin
        int row0 = 0;
        int row1 = 0;
        int idx0 = 0;
        int idx1 = 0;
        logic r0;
        logic r1;
        logic p0 = 1'b0;
        logic p1 = 1'b0;
        ts0_byte = 8'h00;
        ts1_byte = 8'h00;
        forever begin
            @(negedge clk);
            r0 = ts0_byte_rd;
            r1 = ts1_byte_rd;
            if (ts0_row_done) row0++;
            if (ts1_row_done) row1++;
            if (r0 && !p0) idx0 = 0;
            if (r1 && !p1) idx1 = 0;
            p0 = r0;
            p1 = r1;
            @(posedge clk);
            #1;
            if (r0) begin
                ts0_byte = gen(0, row0, idx0);
                sb.push_back(ts0_byte);
                idx0++;
            end else begin
                ts0_byte = 8'($urandom);
            end
            if (r1) begin
                ts1_byte = gen(1, row1, idx1);
                sb.push_back(ts1_byte);
                idx1++;
            end else begin
                ts1_byte = 8'($urandom);
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (!reset_n) begin
            rd0_run = 0;
            rd1_run = 0;
            en_run  = 0;
            prev_rd = 1'b0;
            sb.delete();
        end else begin
            chk("rd_excl", 32'(ts0_byte_rd & ts1_byte_rd), 32'd0);
            chk("done_excl", 32'(ts0_row_done & ts1_row_done), 32'd0);
            if ((ts0_byte_rd | ts1_byte_rd) && !prev_rd) begin
                chk("grant_pending", 32'(exp_grant.size() > 0), 32'd1);
                if (exp_grant.size() > 0) begin
                    logic [2:0] g;
                    g = exp_grant.pop_front();
                    chk("grant_ch", 32'(ts1_byte_rd), 32'(g[2]));
                    chk("grant_mode", 32'(rs_mode), 32'(g[1:0]));
                    cur_mode = g[1:0];
                end
            end
            if (ts0_byte_rd) begin
                rd0_run++;
                rd0_tot++;
            end else if (rd0_run != 0) begin
                chk("rd0_len", 32'(rd0_run), 32'(ROW));
                rd0_run = 0;
            end
            if (ts1_byte_rd) begin
                rd1_run++;
                rd1_tot++;
            end else if (rd1_run != 0) begin
                chk("rd1_len", 32'(rd1_run), 32'(ROW));
                rd1_run = 0;
            end
            if (rs_en_in) begin
                en_run++;
                en_tot++;
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("din", 32'(rs_din), 32'(sb.pop_front()));
                chk("mode_stable", 32'(rs_mode), 32'(cur_mode));
                if (en_run == ROW) begin
                    rows_streamed++;
                    last_en_cyc = cyc;
                end
            end else if (en_run != 0) begin
                chk("en_len", 32'(en_run), 32'(ROW));
                en_run = 0;
            end
            if (ts0_row_done | ts1_row_done) begin
                done_tot++;
                done_cyc = cyc;
                chk("done_pending", 32'(exp_done.size() > 0), 32'd1);
                if (exp_done.size() > 0) begin
                    logic [2:0] d;
                    d = exp_done.pop_front();
                    chk("done_ch", 32'(ts1_row_done), 32'(d[2]));
                    chk("done_fail", 32'(ts1_row_done ? ts1_row_fail : ts0_row_fail),
                        32'(d[1]));
                    chk("done_timeout", 32'(rs_timeout), 32'(d[0]));
                end
            end else begin
                chk("timeout_stray", 32'(rs_timeout), 32'd0);
            end
            prev_rd = ts0_byte_rd | ts1_byte_rd;
        end
    end

    task automatic wait_stream(input int snap, input int bound);
        int n = 0;
        while (rows_streamed == snap && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk("stream_seen", 32'(rows_streamed - snap), 32'd1);
    endtask

    task automatic wait_done(input int snap, input int bound);
        int n = 0;
        while (done_tot == snap && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", 32'(done_tot - snap), 32'd1);
    endtask

    // Finish pulse visible k cycles after the last rs_en_in.
    task automatic fin_at(input int k, input logic c);
        repeat (k - 1) @(posedge clk);
        #1;
        rs_row_finish = 1'b1;
        rs_cor_fail   = c;
        @(posedge clk);
        #1;
        rs_row_finish = 1'b0;
        rs_cor_fail   = 1'b0;
    endtask

    initial begin
        int s_rows;
        int s_done;
        int s_rd0;
        int s_rd1;
        int s_en;
        int n;
        reset_n       = 1'b0;
        ts0_row_req   = 1'b0;
        ts1_row_req   = 1'b0;
        ts0_rs_mode   = 2'b01;
        ts1_rs_mode   = 2'b11;
        rs_row_finish = 1'b0;
        rs_cor_fail   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single ts0 row, mode change mid-row ignored.
        exp_grant.push_back({1'b0, 2'b01});
        exp_done.push_back(3'b000);
        s_rows = rows_streamed;
        s_done = done_tot;
        s_rd0  = rd0_tot;
        s_rd1  = rd1_tot;
        s_en   = en_tot;
        @(posedge clk);
        #1;
        ts0_row_req = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        ts0_rs_mode = 2'b11;
        wait_stream(s_rows, 600);
        fin_at(100, 1'b0);
        wait_done(s_done, 20);
        #1;
        ts0_row_req = 1'b0;
        ts0_rs_mode = 2'b01;
        chk("t1_done_lat", 32'(done_cyc - last_en_cyc), 32'd101);
        chk("t1_rd0_cnt", 32'(rd0_tot - s_rd0), 32'(ROW));
        chk("t1_en_cnt", 32'(en_tot - s_en), 32'(ROW));
        chk("t1_ts1_rd", 32'(rd1_tot - s_rd1), 32'd0);
        chk("t1_idle", 32'(rs_busy), 32'd0);

        // Both requesting from reset, three rows each.
        @(negedge clk);
        reset_n = 1'b0;
        ts0_row_req = 1'b1;
        ts1_row_req = 1'b1;
        ts0_rs_mode = 2'b01;
        ts1_rs_mode = 2'b10;
        for (int r = 0; r < 6; r++)
            exp_grant.push_back((r % 2 == 0) ? 3'b001 : 3'b110);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 6; r++) begin
            s_rows = rows_streamed;
            s_done = done_tot;
            exp_done.push_back({1'(r % 2), 2'b00});
            wait_stream(s_rows, 600);
            fin_at(5, 1'b0);
            wait_done(s_done, 20);
            #1;
            if (r == 4) ts0_row_req = 1'b0;
            if (r == 5) ts1_row_req = 1'b0;
        end

        // ts1 decoder never finishes; ts0 waits behind it.
        exp_grant.push_back({1'b1, 2'b10});
        exp_grant.push_back({1'b0, 2'b01});
        exp_done.push_back(3'b111);
        s_rows = rows_streamed;
        s_done = done_tot;
        @(posedge clk);
        #1;
        ts1_row_req = 1'b1;
        wait_stream(s_rows, 600);
        #1;
        ts0_row_req = 1'b1;
        wait_done(s_done, 2200);
        #1;
        ts1_row_req = 1'b0;
        chk("t3_timeout_lat", 32'(done_cyc - last_en_cyc), 32'(TOC + 1));

        // ts0 row: spurious finish mid-FEED, then a failing finish.
        exp_done.push_back(3'b010);
        s_rows = rows_streamed;
        s_done = done_tot;
        n = 0;
        while (rd0_run < 100 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("t4_feed_seen", 32'(rd0_run >= 100), 32'd1);
        #1;
        rs_row_finish = 1'b1;
        rs_cor_fail   = 1'b1;
        @(posedge clk);
        #1;
        rs_row_finish = 1'b0;
        rs_cor_fail   = 1'b0;
        wait_stream(s_rows, 600);
        fin_at(20, 1'b1);
        wait_done(s_done, 20);
        #1;
        ts0_row_req = 1'b0;
        chk("t4_done_lat", 32'(done_cyc - last_en_cyc), 32'd21);

        // Finish lands on the cycle that would otherwise time out.
        exp_grant.push_back({1'b0, 2'b01});
        exp_done.push_back(3'b000);
        s_rows = rows_streamed;
        s_done = done_tot;
        @(posedge clk);
        #1;
        ts0_row_req = 1'b1;
        wait_stream(s_rows, 600);
        fin_at(TOC, 1'b0);
        wait_done(s_done, 20);
        #1;
        ts0_row_req = 1'b0;
        chk("t5_done_lat", 32'(done_cyc - last_en_cyc), 32'(TOC + 1));

        // Reset mid-FEED aborts silently; the pending row restarts.
        exp_grant.push_back({1'b0, 2'b01});
        s_done = done_tot;
        @(posedge clk);
        #1;
        ts0_row_req = 1'b1;
        n = 0;
        while (rd0_run < 120 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("t6_feed_seen", 32'(rd0_run >= 120), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outs", 32'(outs), 32'd0);
        repeat (3) @(posedge clk);
        exp_grant.push_back({1'b0, 2'b01});
        exp_done.push_back(3'b000);
        s_rows = rows_streamed;
        @(negedge clk);
        reset_n = 1'b1;
        wait_stream(s_rows, 600);
        fin_at(10, 1'b0);
        wait_done(s_done, 20);
        #1;
        ts0_row_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("end_grant_q", 32'(exp_grant.size()), 32'd0);
        chk("end_done_q", 32'(exp_done.size()), 32'd0);
        chk("end_sb", 32'(sb.size()), 32'd0);
        chk("end_busy", 32'(rs_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
